shift_rr_arbiter: RTL and testbench

Shares one right-shift datapath between two requesters, each using a valid/ready request channel. A round-robin arbiter grants one request per cycle. The granted operands go through the combinational shift-right datapath, and the result is captured in a single output register. The result is returned on a valid/ready response channel tagged with the requester ID. The block sits between ALU issue logic and the shared shifter.

---
 rtl/shift_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_shift_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rr_arbiter.sv
// shift_rr_arbiter: two valid/ready requesters share one right-shift datapath.
// A round-robin arbiter grants at most one request per cycle. The shifted
// result is held in a single output register and returned on a valid/ready
// response channel, tagged with the ID of the requester that produced it.
module shift_rr_arbiter #(
   parameter int NBITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [NBITS-1:0] req0_a,
   input  logic [NBITS-1:0] req0_b,
   input  logic             req0_arith,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [NBITS-1:0] req1_a,
   input  logic [NBITS-1:0] req1_b,
   input  logic             req1_arith,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [NBITS-1:0] rsp_data,
   output logic             rsp_id
);

   // Output register occupancy; FULL is the same thing as rsp_valid.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state_reg, state_next;
   logic             ptr_reg, ptr_next;
   logic [NBITS-1:0] data_reg, data_next;
   logic             id_reg, id_next;

   logic             can_accept;
   logic             any_valid;
   logic             grant_sel;
   logic             accept;

   logic [NBITS-1:0] sel_a;
   logic [NBITS-1:0] sel_b;
   logic             sel_arith;
   logic             fill_bit;
   logic [NBITS-1:0] shift_result;

   // stage[i] is the operand after the first i amount bits have been applied
   logic [NBITS-1:0] stage [0:NBITS];

   // Capacity: the output register can take a new result when it is empty
   // or when its current result leaves in this same cycle.
   assign can_accept = (state_reg == ST_EMPTY) || rsp_ready;
   assign any_valid  = req0_valid || req1_valid;
   assign accept     = can_accept && any_valid;

   // Grant: a lone requester wins outright; on a tie the pointer decides.
   always_comb begin
      grant_sel = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_sel = ptr_reg;
      end else if (req1_valid) begin
         grant_sel = 1'b1;
      end
   end

   assign req0_ready = can_accept && req0_valid && (grant_sel == 1'b0);
   assign req1_ready = can_accept && req1_valid && (grant_sel == 1'b1);

   // Route the granted requester's operands into the shared shifter.
   always_comb begin
      sel_a     = req0_a;
      sel_b     = req0_b;
      sel_arith = req0_arith;
      if (grant_sel) begin
         sel_a     = req1_a;
         sel_b     = req1_b;
         sel_arith = req1_arith;
      end
   end

   assign fill_bit = sel_arith & sel_a[NBITS-1];
   assign stage[0] = sel_a;

   // Logarithmic shifter: stage gi shifts right by 2^gi when amount bit gi
   // is set. Stages whose distance reaches NBITS flush the word to fill.
   generate
      for (genvar gi = 0; gi < NBITS; gi++) begin : gen_stage
         localparam int SH = (gi >= 30) ? NBITS :
                             (((1 << gi) > NBITS) ? NBITS : (1 << gi));
         if (SH >= NBITS) begin : gen_flush
            assign stage[gi+1] = sel_b[gi] ? {NBITS{fill_bit}} : stage[gi];
         end else begin : gen_shift
            assign stage[gi+1] = sel_b[gi] ?
                                 {{SH{fill_bit}}, stage[gi][NBITS-1:SH]} :
                                 stage[gi];
         end
      end
   endgenerate

   assign shift_result = stage[NBITS];

   // Next-state logic for occupancy, result register and priority pointer.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      data_next  = data_reg;
      id_next    = id_reg;
      unique case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (rsp_ready && !accept) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
      if (accept) begin
         data_next = shift_result;
         id_next   = grant_sel;
         // The loser of this cycle gets priority on the next tie.
         ptr_next  = ~grant_sel;
      end
   end

   // State registers; reset discards any pending result and rearms req0 priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_EMPTY;
         ptr_reg   <= 1'b0;
         data_reg  <= '0;
         id_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         data_reg  <= data_next;
         id_reg    <= id_next;
      end
   end

   assign rsp_valid = (state_reg == ST_FULL);
   assign rsp_data  = data_reg;
   assign rsp_id    = id_reg;

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Scoreboard bench for shift_rr_arbiter: stimulus pushes hand-computed
// results when a request is accepted; a negedge monitor pops and compares
// on every response handshake.
module tb_shift_rr_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req0_ready, req0_arith;
   logic [3:0] req0_a, req0_b;
   logic       req1_valid, req1_ready, req1_arith;
   logic [3:0] req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [3:0] rsp_data;

   int checks = 0;
   int errors = 0;

   logic [4:0] sb [$];      // {id, data}
   logic       id_log [$];  // ids in response order

   shift_rr_arbiter #(.NBITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_arith (req0_arith),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_arith (req1_arith),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one line per completed response transaction.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d data=%b expected no response", rsp_id, rsp_data);
         end else begin
            logic [4:0] e;
            e = sb.pop_front();
            $display("rsp id=%0d data=%b (expected id=%0d data=%b)", rsp_id, rsp_data, e[4], e[3:0]);
            check("rsp_data", 32'(rsp_data), 32'(e[3:0]));
            check("rsp_id", 32'(rsp_id), 32'(e[4]));
         end
         id_log.push_back(rsp_id);
      end
   end

   // Present one request on channel id and hold it until accepted.
   task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic ar, input logic [3:0] exp, output int waited);
      logic rdy;
      logic ok;
      ok = 1'b0;
      waited = 0;
      if (id) begin
         req1_a = a; req1_b = b; req1_arith = ar; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_arith = ar; req0_valid = 1'b1;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         rdy = id ? req1_ready : req0_ready;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
         waited++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no ready on req%0d expected ready within 50 cycles", id);
      end else begin
         sb.push_back({id, exp});
         @(posedge clk);
         #1;
         // Result is registered on the accept edge.
         check("latency_valid", 32'(rsp_valid), 32'd1);
         check("latency_data", 32'(rsp_data), 32'(exp));
         check("latency_id", 32'(rsp_id), 32'(id));
      end
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int base;
      rst = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_arith = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_arith = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("reset_valid", 32'(rsp_valid), 32'd0);
      check("reset_data", 32'(rsp_data), 32'd0);
      check("reset_id", 32'(rsp_id), 32'd0);
      check("reset_rdy0", 32'(req0_ready), 32'd0);
      check("reset_rdy1", 32'(req1_ready), 32'd0);
      @(posedge clk);
      #1;

      // 1: single arithmetic shift
      rsp_ready = 1'b1;
      send(1'b0, 4'b1000, 4'b0001, 1'b1, 4'b1100, w);
      check("t1_ready_cycle0", 32'(w), 32'd0);
      drain();

      // 2: tie after reset goes to req0, then req1
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      base = id_log.size();
      fork
         begin int w0; send(1'b0, 4'b1111, 4'b0010, 1'b0, 4'b0011, w0); end
         begin int w1; send(1'b1, 4'b0110, 4'b0001, 1'b0, 4'b0011, w1); end
      join
      drain();
      check("t2_first_id", 32'(id_log[base]), 32'd0);
      check("t2_second_id", 32'(id_log[base+1]), 32'd1);

      // 5: fairness, pointer back at 0 after test 2
      base = id_log.size();
      fork
         begin int w0; repeat (4) send(1'b0, 4'b1000, 4'b0011, 1'b1, 4'b1111, w0); end
         begin int w1; repeat (4) send(1'b1, 4'b1000, 4'b0011, 1'b0, 4'b0001, w1); end
      join
      drain();
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t5_id_%0d", i), 32'(id_log[base+i]), 32'(i % 2));
      end

      // 3: backpressure then no-bubble accept
      rsp_ready = 1'b0;
      send(1'b0, 4'b0110, 4'b0001, 1'b0, 4'b0011, w);
      req0_a = 4'b1001; req0_b = 4'b0010; req0_arith = 1'b1; req0_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_rdy0", 32'(req0_ready), 32'd0);
         check("t3_rdy1", 32'(req1_ready), 32'd0);
         check("t3_valid", 32'(rsp_valid), 32'd1);
         check("t3_data", 32'(rsp_data), 32'b0011);
         check("t3_id", 32'(rsp_id), 32'd0);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      send(1'b0, 4'b1001, 4'b0010, 1'b1, 4'b1110, w);
      check("t3_no_bubble", 32'(w), 32'd0);
      drain();

      // 4: shift range extremes
      send(1'b0, 4'b1010, 4'b0100, 1'b1, 4'b1111, w);
      send(1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0000, w);
      send(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0101, w);
      drain();

      // 6: asynchronous reset while FULL
      rsp_ready = 1'b0;
      send(1'b0, 4'b1000, 4'b0001, 1'b1, 4'b1100, w);
      #1 rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(rsp_valid), 32'd0);
      check("t6_async_data", 32'(rsp_data), 32'd0);
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      rsp_ready = 1'b1;
      base = id_log.size();
      fork
         begin int w0; send(1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0001, w0); end
         begin int w1; send(1'b1, 4'b1100, 4'b0010, 1'b1, 4'b1111, w1); end
      join
      drain();
      check("t6_first_id", 32'(id_log[base]), 32'd0);
      check("t6_second_id", 32'(id_log[base+1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
